// File: rtl/synchro_feeder_if.sv
// Bundle of every handshake and bus signal between synchro_feeder and its
// upstream source, the synchro receiver and the host.
//   upstream : in_valid, in_char, in_ready
//   host     : start, frame_len, busy, done, result, err (+ o_sum)
//   receiver : write, o_char, full, check, deg
// Modport slave is the feeder side; modport master is the environment side.
// Optional macro SYNCHRO_FEEDER_CHKSUM_EN adds the o_sum signal.
interface synchro_feeder_if #(
    parameter int unsigned DEG_W = 14
);
    logic             in_valid;
    logic [7:0]       in_char;
    logic             in_ready;
    logic             start;
    logic [5:0]       frame_len;
    logic             write;
    logic [7:0]       o_char;
    logic             full;
    logic             check;
    logic [DEG_W-1:0] deg;
    logic             busy;
    logic             done;
    logic [DEG_W-1:0] result;
    logic             err;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
    logic [7:0]       o_sum;
`endif

    modport slave (
        input  in_valid, in_char, start, frame_len, full, check, deg,
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
        output o_sum,
`endif
        output in_ready, write, o_char, busy, done, result, err
    );

    modport master (
        output in_valid, in_char, start, frame_len, full, check, deg,
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
        input  o_sum,
`endif
        input  in_ready, write, o_char, busy, done, result, err
    );
endinterface

// File: rtl/synchro_feeder.sv
// Transmit-side feeder for the synchro character receiver. Buffers upstream
// characters in a FIFO, sends a frame of frame_len characters as single-cycle
// write strobes spaced by at least GAP idle cycles, honours receiver full,
// then waits for the receiver check pulse and latches deg into result.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : synchro_feeder_if.slave (upstream push, host control/status,
//          receiver strobe/backpressure/result)
// Optional macro SYNCHRO_FEEDER_CHKSUM_EN: drives bus.o_sum, the modulo-256
// sum of characters written in the current frame.
module synchro_feeder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned GAP     = 200,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned DEG_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    synchro_feeder_if.slave   bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

    state_t           r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_in_ready;
    logic [5:0]       r_remaining;
    logic [GW-1:0]    r_gap_cnt;
    logic [TW-1:0]    r_tmo_cnt;
    logic             r_write;
    logic [7:0]       r_o_char;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [DEG_W-1:0] r_result;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
    logic [7:0]       r_sum;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [7:0]       w_head;
    logic [CW-1:0]    w_count_nxt;

    // FIFO handshake; a pop is exactly a SEND cycle that issues a strobe
    assign w_push      = bus.in_valid && r_in_ready;
    assign w_pop       = (r_state == S_SEND) && (r_count != '0) && !bus.full;
    assign w_last      = (r_remaining == 6'd1);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // FIFO storage; contents are don't-care once the count says empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_char;
        end
    end

    // FIFO pointers, occupancy and registered in_ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // Frame control FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_write     <= 1'b0;
            r_o_char    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gap_cnt <= '0;
                    r_tmo_cnt <= '0;
                    if (bus.start && (bus.frame_len != 6'd0)) begin
                        r_remaining <= bus.frame_len;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
                        r_sum       <= '0;
`endif
                    end
                end
                S_SEND: begin
                    r_gap_cnt <= '0;
                    r_tmo_cnt <= '0;
                    if (w_pop) begin
                        r_write     <= 1'b1;
                        r_o_char    <= w_head;
                        r_remaining <= r_remaining - 6'd1;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
                        r_sum       <= r_sum + w_head;
`endif
                        // With no gap configured, skip the GAP state entirely
                        if (GAP == 0) begin
                            r_state <= w_last ? S_WAIT : S_SEND;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_tmo_cnt <= '0;
                    // GAP cycles here plus the strobe cycle give GAP+1 spacing
                    if (r_gap_cnt == GW'(GAP - 1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= (r_remaining != 6'd0) ? S_SEND : S_WAIT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.check) begin
                        r_result <= bus.deg;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.write    = r_write;
    assign bus.o_char   = r_o_char;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.err      = r_err;
`ifdef SYNCHRO_FEEDER_CHKSUM_EN
    assign bus.o_sum    = r_sum;
`endif
endmodule
